// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the serial adder slice:
//     state_e  - FSM state encoding (IDLE / RUN / DONE)
//     clog2    - ceiling log2, used to size the digit counter
//   Optional feature of the top level: define SERIAL_ADDER_SAT_EN to saturate
//   the sum to all-ones when the final carry is set.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
//   Combinational DIGIT-bit ripple-carry adder.
//   Ports:
//     a_i, b_i  [DIGIT-1:0]  addend digits
//     cin_i                  carry into the least significant bit
//     sum_o     [DIGIT-1:0]  digit sum
//     cout_o                 carry out of the most significant bit
// -----------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o
);

  logic [DIGIT:0] carry;

  // NOTE: every signal driven here gets a default before any conditional
  // or loop assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < DIGIT; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[DIGIT];
  end

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle unsigned adder: sum = a + b + cin, processed DIGIT bits per
//   cycle (LSB digit first) with a carry register between cycles.
//   Configuration macro: SERIAL_ADDER_SAT_EN - when defined, a final carry of 1
//   forces sum to all-ones (cout still reports 1); otherwise sum wraps.
//   Ports:
//     clk, rst            clock (rising edge), async active-high reset
//     in_valid/in_ready   operand handshake; accepted only in IDLE
//     a, b [WIDTH-1:0]    unsigned operands
//     cin                 carry-in
//     out_valid/out_ready result handshake; result held until taken
//     sum [WIDTH-1:0]     registered result
//     cout                registered carry-out of the MSB digit
//     busy                high whenever not IDLE
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CW         = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_final;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a_i    (a_sr_q[DIGIT-1:0]),
    .b_i    (b_sr_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout)
  );

  // New digit enters at the MSB end; written as shifts so DIGIT == WIDTH
  // needs no special case.
  assign sum_next = (sum_sr_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_SAT_EN
  assign sum_final = dig_cout ? '1 : sum_next;
`else
  assign sum_final = sum_next;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)      state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0)   state_d = ST_DONE;
      ST_DONE: if (out_ready)     state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the datapath registers are reset too, because sum/cout must read
  // zero out of reset and a reset mid-operation must discard the partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == ST_IDLE && in_valid) begin
      a_sr_q  <= a;
      b_sr_q  <= b;
      carry_q <= cin;
      cnt_q   <= CW'(NUM_DIGITS - 1);
    end else if (state_q == ST_RUN) begin
      a_sr_q   <= a_sr_q >> DIGIT;
      b_sr_q   <= b_sr_q >> DIGIT;
      carry_q  <= dig_cout;
      sum_sr_q <= sum_next;
      cnt_q    <= cnt_q - CW'(1);
      // Result registers load only on the final digit, so they stay stable
      // throughout DONE whatever the operand inputs do.
      if (cnt_q == '0) begin
        sum_q  <= sum_final;
        cout_q <= dig_cout;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench: a WIDTH=8/DIGIT=1 instance compared every cycle
//   against a cycle-count/arithmetic model, plus a WIDTH=8/DIGIT=4 instance
//   exercised with directed and random operations.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W  = 8;
  localparam int N1 = 8;   // digits for DIGIT=1
  localparam int N4 = 2;   // digits for DIGIT=4

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DIGIT=1 instance
  logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;

  // DIGIT=4 instance
  logic         in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [W-1:0] a4 = '0, b4 = '0;
  logic         in_ready4, out_valid4, cout4, busy4;
  logic [W-1:0] sum4;

  serial_adder #(.WIDTH(W), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {cout, sum} of a+b+cin, with optional saturation of the sum.
  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    int total;
    logic [W:0] r;
    total = int'(x) + int'(y) + int'(c);
    r = total[W:0];
`ifdef SERIAL_ADDER_SAT_EN
    if (r[W]) r[W-1:0] = '1;
`endif
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model for the DIGIT=1 instance: a countdown of cycles until the
  // result appears, and a flag for "result waiting to be taken".
  // ---------------------------------------------------------------------------
  int         m_left   = 0;
  bit         m_have   = 0;
  logic [W:0] m_res    = '0;
  int         m_accepts = 0;
  int         dut_taken = 0;
  bit         chk_en   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_have = 0;
    end else if (m_have) begin
      if (out_ready) m_have = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_have = 1;
    end else if (in_valid) begin
      m_res  = model_add(a, b, cin);
      m_left = N1;
      m_accepts++;
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) dut_taken++;
  end

  // Per-cycle compare, sampled mid-period.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, (m_left == 0 && !m_have)});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_have});
      check("busy",      {31'd0, busy},      {31'd0, (m_left != 0 || m_have)});
      if (m_have) check("result", {23'd0, cout, sum}, {23'd0, m_res});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic [W:0] exp, input int exp_lat, input string name);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
    @(posedge clk); #1;                    // accepting edge
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, {23'd0, cout, sum}, {23'd0, exp});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_ready_after_take"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op4(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic [W:0] exp, input string name);
    int lat;
    @(posedge clk); #1;
    in_valid4 = 1'b1; a4 = xa; b4 = xb; cin4 = xc;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    a4 = ~xa; b4 = ~xb; cin4 = ~xc;        // operands must not leak into the result
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, N4);
    check({name, "_result"}, {23'd0, cout4, sum4}, {23'd0, exp});
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check({name, "_ready_after_take"}, {31'd0, in_ready4}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int taken0;
    int target;
    int cyc;
    logic [W:0] exp_sat;
    logic [W:0] e;

    // Hand-computed pins for the model itself.
    check("pin_01_01", {23'd0, model_add(8'h01, 8'h01, 1'b0)}, 32'h002);
    check("pin_00_00", {23'd0, model_add(8'h00, 8'h00, 1'b0)}, 32'h000);
    check("pin_ff_ff_1", {23'd0, model_add(8'hFF, 8'hFF, 1'b1)}, 32'h1FF);
`ifdef SERIAL_ADDER_SAT_EN
    exp_sat = 9'h1FF;
    check("pin_9c_64_1", {23'd0, model_add(8'h9C, 8'h64, 1'b1)}, 32'h1FF);
`else
    exp_sat = 9'h100;
    check("pin_9c_64_1", {23'd0, model_add(8'h9C, 8'h64, 1'b1)}, 32'h101);
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_sum",       {24'd0, sum},       32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    chk_en = 1'b1;

    // Directed DIGIT=1 operations.
    run_op(8'h01, 8'h01, 1'b0, 9'h002, N1, "inc");
    run_op(8'hFF, 8'h01, 1'b0, exp_sat, N1, "wrap");
    run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, N1, "allones");
    run_op(8'h00, 8'h00, 1'b0, 9'h000, N1, "zeros");

    // Backpressure: result held 5 cycles with in_valid pulses and changing operands.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h37; b = 8'h4A; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, N1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      check("bp_result",    {23'd0, cout, sum},  32'h081);
      check("bp_out_valid", {31'd0, out_valid},  32'd1);
      check("bp_in_ready",  {31'd0, in_ready},   32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the 4th RUN cycle.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_busy",      {31'd0, busy},      32'd0);
    #2 rst = 1'b0;
    run_op(8'h10, 8'h20, 1'b0, 9'h030, N1, "after_rst");

    // DIGIT=4 instance.
    run_op4(8'h9C, 8'h64, 1'b1, exp_sat | 9'h001, "d4_spec");
    for (int i = 0; i < 20; i++) begin
      a4 = W'($urandom); b4 = W'($urandom); cin4 = 1'($urandom);
      e = model_add(a4, b4, cin4);
      run_op4(a4, b4, cin4, e, "d4_rand");
    end

    // Back-to-back random operations with random backpressure.
    taken0 = dut_taken;
    target = m_accepts + 1000;
    in_valid = 1'b1;
    cyc = 0;
    while (m_accepts < target && cyc < 60000) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((m_left != 0 || m_have) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("rand_drain_done", {31'd0, in_ready}, 32'd1);
    check("rand_results", dut_taken - taken0, 1000);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
